// File: rtl/imem_program_loader_pkg.sv
// rtl/imem_program_loader_pkg.sv - shared state encoding, error codes and sizes for the program loader
package imem_loader_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_LO = 3'd1;
  localparam logic [2:0] ST_LEN_HI = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_LEN_LO = ST_LEN_LO,
    S_LEN_HI = ST_LEN_HI,
    S_DATA   = ST_DATA,
    S_CHECK  = ST_CHECK,
    S_DONE   = ST_DONE,
    S_ERROR  = ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_CHK  = 2'b10;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - byte stream in, instruction-memory write port out
interface imem_program_loader_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader_byte_packer.sv
// rtl/imem_program_loader_byte_packer.sv - little-endian byte-to-word packer with running XOR checksum
module loader_byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_in,
  output logic                  last_lane,
  output logic                  word_ready,
  output logic [DATA_WIDTH-1:0] word,
  output logic [7:0]            checksum
);
  localparam int IDX_W = $clog2(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic [7:0]            r_chk;
  logic                  r_ready;

  assign last_lane  = (r_idx == LAST_IDX);
  assign word_ready = r_ready;
  assign word       = r_word;
  assign checksum   = r_chk;

  // The lane register is only overwritten lane by lane, so the completed word
  // stays intact through the write-pulse cycle even if lane 0 is refilled then.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_word  <= '0;
      r_chk   <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= accept && last_lane;
      if (clear) begin
        r_idx <= '0;
        r_chk <= '0;
      end else if (accept) begin
        r_word[{r_idx, 3'b000} +: 8] <= byte_in;
        r_chk                        <= r_chk ^ byte_in;
        r_idx                        <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - framed byte-stream loader that fills instruction memory and gates CPU reset
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  imem_program_loader_if.slave  bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            error_code,
  output logic [ADDR_WIDTH:0]   words_loaded
);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  state_t                r_state, w_next;
  logic                  w_in_ready, w_accept, w_start_ok;
  logic                  w_pack_accept, w_last_lane, w_word_ready, w_word_done, w_last_word;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_chk;
  logic [15:0]           w_len16;
  logic                  w_len_bad;

  logic [7:0]            r_len_lo;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_words;
  logic                  r_cpu_hold, r_busy, r_done, r_error;
  logic [1:0]            r_error_code;

  assign w_accept      = bus.in_valid && w_in_ready;
  assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
  assign w_pack_accept = w_accept && (r_state == S_DATA);
  assign w_word_done   = w_pack_accept && w_last_lane;
  assign w_last_word   = w_word_done && ((r_words + 1'b1) == r_len);
  assign w_len16       = {bus.in_data, r_len_lo};
  assign w_len_bad     = (w_len16 == 16'd0) || ({1'b0, w_len16} > MAX_WORDS);

  loader_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (w_start_ok),
    .accept     (w_pack_accept),
    .byte_in    (bus.in_data),
    .last_lane  (w_last_lane),
    .word_ready (w_word_ready),
    .word       (w_word),
    .checksum   (w_chk)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: if (start) w_next = S_LEN_LO;
      S_LEN_LO: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = w_len_bad ? S_ERROR : S_DATA;
      end
      S_DATA: begin
        w_in_ready = 1'b1;
        if (w_last_word) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_in_ready = 1'b1;
        if (w_accept) w_next = (bus.in_data == w_chk) ? S_DONE : S_ERROR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // imem_addr is captured with the pre-increment count so the write pulse and
  // the bumped words_loaded land in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_len_lo     <= '0;
      r_len        <= '0;
      r_addr       <= '0;
      r_words      <= '0;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else if (w_start_ok) begin
      r_words      <= '0;
      r_cpu_hold   <= 1'b1;
      r_busy       <= 1'b1;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_error_code <= ERR_NONE;
    end else begin
      r_cpu_hold <= (r_state != S_DONE);
      if (w_accept && (r_state == S_LEN_LO)) r_len_lo <= bus.in_data;
      if (w_accept && (r_state == S_LEN_HI)) begin
        if (w_len_bad) begin
          r_error      <= 1'b1;
          r_error_code <= ERR_LEN;
          r_busy       <= 1'b0;
        end else begin
          r_len <= w_len16[ADDR_WIDTH:0];
        end
      end
      if (w_word_done) begin
        r_addr  <= r_words[ADDR_WIDTH-1:0];
        r_words <= r_words + 1'b1;
      end
      if (w_accept && (r_state == S_CHECK)) begin
        r_busy <= 1'b0;
        if (bus.in_data == w_chk) begin
          r_done <= 1'b1;
        end else begin
          r_error      <= 1'b1;
          r_error_code <= ERR_CHK;
        end
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.imem_we    = w_word_ready;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = w_word;
  assign cpu_hold       = r_cpu_hold;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign error_code     = r_error_code;
  assign words_loaded   = r_words;

endmodule

// File: tb/tb_imem_program_loader.sv
// tb/tb_imem_program_loader.sv - directed self-checking bench for imem_program_loader
module tb_imem_program_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       cpu_hold, busy, done, error;
  logic [1:0] error_code;
  logic [6:0] words_loaded;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  logic [7:0]  frame[$];
  logic [5:0]  wq_addr[$];
  logic [31:0] wq_data[$];

  always #5 clock = ~clock;

  imem_program_loader_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) lif ();

  imem_program_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .bus          (lif),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .error_code   (error_code),
    .words_loaded (words_loaded)
  );

  always @(negedge clock) begin
    if (reset === 1'b1 && lif.imem_we === 1'b1) begin
      wq_addr.push_back(lif.imem_addr);
      wq_data.push_back(lif.imem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) begin
      lif.in_valid = 1'b0;
      @(negedge clock);
    end
    lif.in_valid = 1'b1;
    lif.in_data  = b;
    n = 0;
    while (lif.in_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("in_ready_wait", lif.in_ready, 1);
    @(negedge clock);
    lif.in_valid = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input int maxgap);
    for (int i = lo; i <= hi; i++)
      send_byte(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic new_load();
    wq_addr.delete();
    wq_data.delete();
    pulse_start();
  endtask

  task automatic check_good_result(input string tag);
    chk({tag, "_nwrites"}, wq_addr.size(), 2);
    if (wq_addr.size() == 2) begin
      chk({tag, "_addr0"}, wq_addr[0], 0);
      chk({tag, "_data0"}, wq_data[0], 32'h20080005);
      chk({tag, "_addr1"}, wq_addr[1], 1);
      chk({tag, "_data1"}, wq_data[1], 32'h01095020);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_cpu_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_words"}, words_loaded, 2);
  endtask

  initial begin
    logic [7:0] x;
    reset        = 1'b0;
    start        = 1'b0;
    lif.in_valid = 1'b0;
    lif.in_data  = 8'h00;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_in_ready", lif.in_ready, 0);
    chk("rst_imem_we", lif.imem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_error_code", error_code, 0);
    chk("rst_words", words_loaded, 0);
    chk("rst_addr", lif.imem_addr, 0);
    chk("rst_wdata", lif.imem_wdata, 0);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("idle_in_ready", lif.in_ready, 0);
    chk("idle_cpu_hold", cpu_hold, 1);

    // Good load, back-to-back bytes
    frame = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h50, 8'h09, 8'h01, 8'h55};
    new_load();
    chk("start_busy", busy, 1);
    send_range(0, 10, 0);
    repeat (3) @(negedge clock);
    check_good_result("good");

    // Bad checksum
    frame[10] = 8'h54;
    new_load();
    send_range(0, 10, 0);
    repeat (3) @(negedge clock);
    chk("badchk_nwrites", wq_addr.size(), 2);
    chk("badchk_error", error, 1);
    chk("badchk_code", error_code, 2'b10);
    chk("badchk_cpu_hold", cpu_hold, 1);
    chk("badchk_done", done, 0);
    chk("badchk_busy", busy, 0);

    // N = 0
    frame = '{8'h00, 8'h00};
    new_load();
    send_range(0, 1, 0);
    chk("len0_code", error_code, 2'b01);
    chk("len0_error", error, 1);
    repeat (3) @(negedge clock);
    chk("len0_nwrites", wq_addr.size(), 0);
    chk("len0_in_ready", lif.in_ready, 0);

    // N = 65
    frame = '{8'h41, 8'h00};
    new_load();
    send_range(0, 1, 0);
    repeat (3) @(negedge clock);
    chk("len65_code", error_code, 2'b01);
    chk("len65_nwrites", wq_addr.size(), 0);
    chk("len65_cpu_hold", cpu_hold, 1);

    // N = 64, full memory
    frame = '{8'h40, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      frame.push_back(8'(i));
      frame.push_back(8'hA0);
      frame.push_back(8'(i * 2));
      frame.push_back(8'h3C);
      x = x ^ 8'(i) ^ 8'hA0 ^ 8'(i * 2) ^ 8'h3C;
    end
    frame.push_back(x);
    new_load();
    send_range(0, frame.size() - 1, 0);
    repeat (3) @(negedge clock);
    chk("len64_nwrites", wq_addr.size(), 64);
    if (wq_addr.size() == 64) begin
      chk("len64_first_addr", wq_addr[0], 0);
      chk("len64_first_data", wq_data[0], 32'h3C00A000);
      chk("len64_last_addr", wq_addr[63], 63);
      chk("len64_last_data", wq_data[63], 32'h3C7EA03F);
    end
    chk("len64_done", done, 1);
    chk("len64_words", words_loaded, 64);

    // Random gaps plus an ignored start mid-DATA
    frame = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h50, 8'h09, 8'h01, 8'h55};
    new_load();
    send_range(0, 5, 3);
    @(negedge clock);
    pulse_start();
    chk("midstart_busy", busy, 1);
    chk("midstart_words", words_loaded, 1);
    chk("midstart_in_ready", lif.in_ready, 1);
    send_range(6, 10, 3);
    repeat (3) @(negedge clock);
    check_good_result("gaps");

    // Reset mid-load after 5 data bytes
    new_load();
    send_range(0, 6, 0);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", lif.in_ready, 0);
    chk("midrst_imem_we", lif.imem_we, 0);
    chk("midrst_cpu_hold", cpu_hold, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_words", words_loaded, 0);
    chk("midrst_addr", lif.imem_addr, 0);
    chk("midrst_nwrites", wq_addr.size(), 1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    new_load();
    send_range(0, 10, 0);
    repeat (3) @(negedge clock);
    check_good_result("after_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_program_loader.md
Name: imem_program_loader

Overview:
- Writer side of the instruction memory that single_cycle_processor fetches from.
- Receives a framed byte stream over a valid/ready interface and assembles little-endian 32-bit instructions.
- Writes each instruction into the instruction-memory write port and verifies a checksum.
- Holds the processor in reset until a good image is loaded, so boot is deterministic.

Parameters:
- ADDR_WIDTH, 6, instruction-memory word-address width; capacity is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width; fixed at 32, i.e. 4 bytes per word.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted on a cycle where in_valid && in_ready.
- imem_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_WIDTH  word address of the write.
- imem_wdata  out  32  assembled instruction.
- cpu_hold  out  1  high keeps the processor in reset.
- busy  out  1  load in progress.
- done  out  1  image loaded and verified; sticky until next start.
- error  out  1  load failed; sticky until next start.
- error_code  out  2  00 none, 01 bad length, 10 bad checksum.
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current or last load.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
  - cpu_hold=1, busy=0, done=0, error=0, error_code=00, words_loaded=0.
  - Internal byte index, length and checksum all cleared.
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then N×4 data bytes (each word LSB first), then one CHK byte.
- CHK is the XOR of all data bytes only; the length bytes are excluded.
- States: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
- start:
  - Honoured in IDLE, DONE or ERROR: go to LEN_LO.
  - On entry, clear done, error, error_code, words_loaded, checksum and byte index; set busy=1 and cpu_hold=1.
  - Ignored in all other states.
- in_ready=1 exactly in LEN_LO, LEN_HI, DATA and CHECK; 0 otherwise. The block never stalls inside these states.
- LEN_LO: on accept, latch the low byte and go to LEN_HI.
- LEN_HI: on accept, form N.
  - N==0 or N>2**ADDR_WIDTH: go to ERROR with error_code=01.
  - Otherwise go to DATA.
- DATA:
  - Each accepted byte shifts into the word at lane byte_idx (0..3) and is XORed into the checksum.
  - On the byte_idx==3 accept:
    - On the next cycle, imem_we=1 for exactly one cycle, with imem_addr = current word index and imem_wdata = assembled word.
    - words_loaded increments in that same cycle.
    - byte_idx wraps to 0.
  - A new byte may be accepted during the write-pulse cycle (back-to-back bytes at full rate are supported).
  - After the Nth word's last byte is accepted, go to CHECK.
- CHECK: on accept, compare the byte with the checksum.
  - Equal: go to DONE.
  - Not equal: go to ERROR with error_code=10.
  - The final word's write pulse still occurs regardless.
- DONE: done=1, busy=0, cpu_hold=0 (registered; released the cycle after entering DONE).
- ERROR: error=1, busy=0, cpu_hold=1. Words already written are not rolled back.
- Word address never wraps; the length check guarantees the last index is ≤ 2**ADDR_WIDTH−1.
- in_valid gaps of any length are allowed in every receiving state; there is no timeout.
- reset asserted mid-load: immediate return to reset values. A partial write already pulsed stands; a pending write is dropped.

Decomposition:
- Package imem_loader_pkg holds:
  - state encoding (3-bit localparams for the seven states);
  - ERR_NONE=2'b00, ERR_LEN=2'b01, ERR_CHK=2'b10;
  - BYTES_PER_WORD=4.
- One sub-module, loader_byte_packer:
  - owns byte_idx, the 32-bit shift/lane register and the running XOR checksum;
  - outputs word_ready and word;
  - has a clear input driven on start.
- The top level owns the FSM, the length check, the address counter and the output registers.

Test Plan:
- Reset: hold reset=0 for 3 cycles → cpu_hold=1, in_ready=0, imem_we=0, done=0, error=0, error_code=00, words_loaded=0.
- Good load, no gaps:
  - Stimulus: start, then bytes 02 00 | 05 00 08 20 | 20 50 09 01 | 55.
  - Expect writes addr0=0x20080005 and addr1=0x01095020, one cycle each.
  - Expect done=1, cpu_hold=0, words_loaded=2, busy=0.
- Bad checksum: same frame with CHK=54 → both writes still occur; error=1, error_code=10, cpu_hold=1, done=0.
- Length errors:
  - N=0 (00 00) → error_code=01 after the second byte, no imem_we.
  - With ADDR_WIDTH=6, N=65 (41 00) → error_code=01, no writes.
  - N=64 → accepted, last write at addr 63.
- Flow control: the good-load frame with random 0–3 cycle in_valid gaps → identical writes and result. A start pulse mid-DATA is ignored (no restart, words_loaded continues).
- Reset mid-load: assert reset after 5 data bytes → reset values immediately. A subsequent complete good-load frame → done=1, words_loaded=2.
